// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan sequencer: holds each digit for DWELL_CNT cycles and
// decodes a frame-coherent snapshot of the hex value, with optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int DWELL_CNT = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [23:0] data_i,
    input  logic [5:0]  point_i,
    input  logic        blank_lead_i,
    output logic [7:0]  seg_data_o,
    output logic [5:0]  sel_o
);

    localparam int CW = (DWELL_CNT > 1) ? $clog2(DWELL_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CNT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   snap_data_q, snap_data_d;
    logic [5:0]    snap_point_q, snap_point_d;
    logic          snap_blank_q, snap_blank_d;
    logic          primed_q, primed_d;
    logic [7:0]    seg_q, seg_d;
    logic [5:0]    sel_q, sel_d;

    logic [5:0]    zero_w;
    logic [5:0]    lz_w;
    logic [7:0]    dig_w [6];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // lz_w[k] is set when digit k and everything to its left is an undotted zero.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign zero_w[gi] = (snap_data_q[gi*4 +: 4] == 4'h0) && !snap_point_q[gi];
            if (gi == 5) begin : g_top
                assign lz_w[gi] = zero_w[gi];
            end else begin : g_rest
                assign lz_w[gi] = zero_w[gi] && lz_w[gi+1];
            end
            if (gi == 0) begin : g_first
                assign dig_w[gi] = {snap_point_q[gi], hex7(snap_data_q[gi*4 +: 4])};
            end else begin : g_other
                assign dig_w[gi] = (snap_blank_q && lz_w[gi]) ? 8'h00
                                 : {snap_point_q[gi], hex7(snap_data_q[gi*4 +: 4])};
            end
        end
    endgenerate

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_data_d  = snap_data_q;
        snap_point_d = snap_point_q;
        snap_blank_d = snap_blank_q;
        primed_d     = primed_q;
        seg_d        = 8'h00;
        sel_d        = 6'b000000;

        if (en_i) begin
            if (!primed_q) begin
                // Priming edge: take the snapshot but keep outputs dark and the dwell
                // counter parked, so digit 0 gets its full dwell from the next edge.
                primed_d     = 1'b1;
                snap_data_d  = data_i;
                snap_point_d = point_i;
                snap_blank_d = blank_lead_i;
            end else begin
                seg_d = dig_w[idx_q];
                sel_d = 6'b000001 << idx_q;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'd5) begin
                        idx_d        = 3'd0;
                        snap_data_d  = data_i;
                        snap_point_d = point_i;
                        snap_blank_d = blank_lead_i;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end else begin
            cnt_d    = '0;
            idx_d    = 3'd0;
            primed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            snap_data_q  <= 24'h000000;
            snap_point_q <= 6'b000000;
            snap_blank_q <= 1'b0;
            primed_q     <= 1'b0;
            seg_q        <= 8'h00;
            sel_q        <= 6'b000000;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_data_q  <= snap_data_d;
            snap_point_q <= snap_point_d;
            snap_blank_q <= snap_blank_d;
            primed_q     <= primed_d;
            seg_q        <= seg_d;
            sel_q        <= sel_d;
        end
    end

    assign seg_data_o = seg_q;
    assign sel_o      = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CNT=4; expected segment codes are hand-decoded.
module tb_seg_scan_ctrl;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_i;
    logic [23:0] data_i;
    logic [5:0]  point_i;
    logic        blank_lead_i;
    logic [7:0]  seg_data_o;
    logic [5:0]  sel_o;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl #(.DWELL_CNT(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .data_i       (data_i),
        .point_i      (point_i),
        .blank_lead_i (blank_lead_i),
        .seg_data_o   (seg_data_o),
        .sel_o        (sel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_digit(input int k, input logic [7:0] seg, input int n);
        logic [5:0] one_hot;
        one_hot = 6'b000001 << k;
        for (int c = 0; c < n; c++) begin
            tick();
            chk($sformatf("sel d%0d c%0d", k, c), {26'd0, sel_o}, {26'd0, one_hot});
            chk($sformatf("seg d%0d c%0d", k, c), {24'd0, seg_data_o}, {24'd0, seg});
        end
        $display("digit %0d x%0d: sel=%b seg=%h", k, n, sel_o, seg_data_o);
    endtask

    task automatic scan_frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] s5);
        scan_digit(0, s0, DW);
        scan_digit(1, s1, DW);
        scan_digit(2, s2, DW);
        scan_digit(3, s3, DW);
        scan_digit(4, s4, DW);
        scan_digit(5, s5, DW);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, " sel"}, {26'd0, sel_o}, 32'd0);
        chk({tag, " seg"}, {24'd0, seg_data_o}, 32'd0);
        $display("%s: sel=%b seg=%h", tag, sel_o, seg_data_o);
    endtask

    initial begin
        rst_n        = 1'b0;
        en_i         = 1'b1;
        data_i       = 24'h012345;
        point_i      = 6'b000000;
        blank_lead_i = 1'b0;

        #25;
        chk_dark("reset hold");
        #2 rst_n = 1'b1;

        // Priming edge keeps outputs dark; digit 0 follows on the next edge.
        tick();
        chk_dark("prime");

        // Basic scan of 012345.
        scan_frame(8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F);

        // Frame coherence: change data while digit 2 is showing.
        scan_digit(0, 8'h6D, DW);
        scan_digit(1, 8'h66, DW);
        scan_digit(2, 8'h4F, 1);
        data_i = 24'hFFFFFF;
        scan_digit(2, 8'h4F, DW - 1);
        scan_digit(3, 8'h5B, DW);
        scan_digit(4, 8'h06, DW);
        scan_digit(5, 8'h3F, DW);

        // Frame of all F; queue the blanking setup for the next frame.
        scan_digit(0, 8'h71, DW);
        blank_lead_i = 1'b1;
        data_i       = 24'h000120;
        point_i      = 6'b000000;
        scan_digit(1, 8'h71, DW);
        scan_digit(2, 8'h71, DW);
        scan_digit(3, 8'h71, DW);
        scan_digit(4, 8'h71, DW);
        scan_digit(5, 8'h71, DW);

        // Leading zeros blanked, point=0.
        scan_digit(0, 8'h3F, DW);
        point_i = 6'b010000;
        scan_digit(1, 8'h5B, DW);
        scan_digit(2, 8'h06, DW);
        scan_digit(3, 8'h00, DW);
        scan_digit(4, 8'h00, DW);
        scan_digit(5, 8'h00, DW);

        // Decimal point on digit 4 stops blanking from digit 4 down.
        scan_digit(0, 8'h3F, DW);
        data_i  = 24'h000000;
        point_i = 6'b000000;
        scan_digit(1, 8'h5B, DW);
        scan_digit(2, 8'h06, DW);
        scan_digit(3, 8'h3F, DW);
        scan_digit(4, 8'hBF, DW);
        scan_digit(5, 8'h00, DW);

        // All-zero value: only digit 0 lit.
        scan_frame(8'h3F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        // Enable drop during digit 3.
        scan_digit(0, 8'h3F, DW);
        scan_digit(1, 8'h00, DW);
        scan_digit(2, 8'h00, DW);
        scan_digit(3, 8'h00, 2);
        en_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_dark($sformatf("disabled c%0d", c));
        end

        // Re-enable with new value and point on digit 0.
        en_i         = 1'b1;
        data_i       = 24'h0ABCDE;
        point_i      = 6'b000001;
        blank_lead_i = 1'b0;
        tick();
        chk_dark("reprime");
        scan_frame(8'hF9, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h3F);

        // Asynchronous reset mid-frame, checked before any further clock edge.
        scan_digit(0, 8'hF9, DW);
        scan_digit(1, 8'h5E, 2);
        #2 rst_n = 1'b0;
        #1;
        chk_dark("async reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Dynamic-scan sequencer for the 6-digit 7-segment display. It takes a 24-bit hex value, decimal-point mask and control flags, and time-multiplexes one digit at a time. For each digit it produces the segment pattern (`seg_data`) and one-hot digit select (`sel`) that feed `ctrl_595`, which serialises them into the 74HC595 chain. It owns digit timing, frame-coherent data capture, hex-to-segment decode and leading-zero blanking.

## Interface
- `DWELL_CNT`, default 50_000: clock cycles each digit is held (1 ms at 50 MHz). Must be ≥ one full `ctrl_595` shift+latch frame; minimum 2.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  scan enable; 0 blanks the display and restarts the scan.
- `data`  in  24  six hex nibbles. `data[3:0]` is digit 0 (rightmost, `sel[0]`); `data[23:20]` is digit 5 (leftmost, `sel[5]`).
- `point`  in  6  decimal point per digit; `point[k]` drives bit 7 of digit k.
- `blank_lead`  in  1  1 enables leading-zero suppression.
- `seg_data`  out  8  segment pattern, active-high: bit0=a … bit6=g, bit7=dp. Goes to `ctrl_595.seg_data`.
- `sel`  out  6  one-hot digit select, active-high. Goes to `ctrl_595.sel`.

## Operation
- State registers:
  - dwell counter `cnt`, 0..DWELL_CNT-1;
  - digit index `idx`, 0..5;
  - snapshot registers `snap_data[23:0]`, `snap_point[5:0]`, `snap_blank`;
  - `primed` flag;
  - output registers `seg_data` and `sel`.
- Counting while `en`=1:
  - `cnt` increments each cycle.
  - When `cnt`==DWELL_CNT-1, `cnt`→0 and `idx` advances (5→0 wraps).
- Snapshot capture. `data`, `point` and `blank_lead` are loaded into the snapshot on the edge where:
  - `en`=1 and `primed`=0 (this edge also sets `primed`), or
  - `en`=1, `cnt`==DWELL_CNT-1 and `idx`==5 (frame wrap).
- Input changes at any other time have no visible effect until the next frame. This prevents tearing.
- Decode of `snap_data` nibble k, hex to segments:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - bit7 = `snap_point[k]`.
- Leading-zero blanking. When `snap_blank`=1, digit k (k≥1) is blanked iff every digit j≥k has nibble 0 and `snap_point[j]`=0.
  - Digit 0 is never blanked.
  - A blanked digit outputs `seg_data`=8'h00; `sel` is still driven one-hot.
- Output update: each enabled cycle, `seg_data`/`sel` ← decode(snapshot, `idx`) and `sel` ← 1<<`idx`.
- `en`=0: on the next edge `seg_data`←8'h00, `sel`←6'b000000, `cnt`←0, `idx`←0, `primed`←0. The scan restarts at digit 0 with a fresh snapshot when `en` returns to 1.

## Timing
- Reset (asynchronous, immediate, no clock needed) clears all of the following: `seg_data`=8'h00, `sel`=6'b000000, `cnt`=0, `idx`=0, `primed`=0, snapshot=0.
- Output latency is 1 cycle: the outputs show the digit for the `idx` held during the previous cycle.
- First enabled edge captures the snapshot and sets `primed`. Digit 0 appears on the following edge.
- Each digit is held exactly DWELL_CNT cycles; a full frame is 6×DWELL_CNT cycles.
- At a frame wrap, digit 5 is still displayed from the old snapshot during the capture cycle. Digit 0 of the next frame uses the new snapshot.
- `en` falling mid-digit blanks the outputs at the next edge; the partial dwell is discarded.
- `sel` is always zero or one-hot; it is never multi-hot, including at wrap and at enable/disable.

## Test plan
- **Reset:** hold `rst_n`=0 for 25 ns with `en`=1, then assert `rst_n` low mid-frame with no clock edge → `seg_data`=8'h00 and `sel`=0 immediately in both cases.
- **Basic scan:** DWELL_CNT=4, `data`=24'h012345, `point`=0, `blank_lead`=0, `en`=1 → repeating pattern of 4 cycles each:
  - `sel`=000001/`seg`=6D, 000010/66, 000100/4F, 001000/5B, 010000/06, 100000/3F;
  - the first digit appears 2 edges after `en` rises.
- **Frame coherence:** change `data` to 24'hFFFFFF while digit 2 is showing → digits 3–5 of the current frame are unchanged (5B, 06, 3F). The next frame shows 71 on all digits.
- **Leading-zero blanking:** `blank_lead`=1, `data`=24'h000120 →
  - `point`=0: digits 5, 4, 3 show 00; digit 2 shows 06, digit 1 shows 5B, digit 0 shows 3F.
  - `point`=6'b010000: digit 5 shows 00, digit 4 shows BF, digit 3 shows 3F.
  - `data`=0: digit 0 shows 3F and all other digits show 00.
- **Enable toggle:** drop `en` during digit 3 → one edge later `seg`=00 and `sel`=0, held while `en`=0. Re-raise `en` with new `data` → the scan restarts at digit 0 (`sel`=000001) showing the new value.
- **Point decode:** `data`=24'h0ABCDE, `point`=6'b000001 → digit 0 shows F9; digits 1–4 show 5E, 39, 7C, 77; digit 5 shows 3F.
